// File: rtl/out_pass_pkg.sv
// Shared mode encodings for the out_pass channel family.
package out_pass_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_BYPASS = 2'b00,
    MODE_REG1   = 2'b01,
    MODE_REGN   = 2'b10,
    MODE_RISE   = 2'b11
  } out_pass_mode_e;

endpackage

// File: rtl/my_mux2.sv
// Standard 2:1 mux cell; config-driven selects map onto this primitive.
module my_mux2 (
  input  logic i_a0,
  input  logic i_a1,
  input  logic i_s,
  output logic o_x
);

  assign o_x = i_s ? i_a1 : i_a0;

endmodule

// File: rtl/out_pass_chan.sv
// One pass channel: shift chain, rising-edge detect, mode mux.
// Optional output inversion is built only when OUT_PASS_INVERT_EN is defined.
module out_pass_chan
  import out_pass_pkg::*;
#(
  parameter int PIPE_DEPTH = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_d,
  input  logic [MODE_W-1:0] i_mode,
`ifdef OUT_PASS_INVERT_EN
  input  logic              i_inv,
`endif
  output logic              o_q
);

  logic [PIPE_DEPTH-1:0] r_chain;
  logic                  w_rise;
  logic                  w_lo;
  logic                  w_hi;
  logic                  w_sel;
  logic                  w_gated;

  // Chain always captures, so switching modes never needs a flush.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[PIPE_DEPTH-2:0], i_d};
    end
  end

  // Stages 0 and 1 double as the RISE history: last sample 1, previous 0.
  assign w_rise = r_chain[0] & ~r_chain[1];

  my_mux2 u_mux_lo  (.i_a0(i_d),                   .i_a1(r_chain[0]), .i_s(i_mode[0]), .o_x(w_lo));
  my_mux2 u_mux_hi  (.i_a0(r_chain[PIPE_DEPTH-1]), .i_a1(w_rise),     .i_s(i_mode[0]), .o_x(w_hi));
  my_mux2 u_mux_out (.i_a0(w_lo),                  .i_a1(w_hi),       .i_s(i_mode[1]), .o_x(w_sel));

  // Registered modes read 0 while reset is high; bypass stays transparent.
  always_comb begin
    w_gated = w_sel;
    if (i_rst && (out_pass_mode_e'(i_mode) != MODE_BYPASS)) begin
      w_gated = 1'b0;
    end else begin
      w_gated = w_sel;
    end
  end

`ifdef OUT_PASS_INVERT_EN
  assign o_q = w_gated ^ i_inv;
`else
  assign o_q = w_gated;
`endif

endmodule

// File: rtl/out_pass_pipe.sv
// NUM_CH independent output pass channels with per-channel mode select.
// Define OUT_PASS_INVERT_EN to add a per-channel output invert bit.
module out_pass_pipe
  import out_pass_pkg::*;
#(
  parameter int NUM_CH       = 8,
  parameter int PIPE_DEPTH   = 3,
`ifdef OUT_PASS_INVERT_EN
  parameter int NoConfigBits = 3 * NUM_CH
`else
  parameter int NoConfigBits = 2 * NUM_CH
`endif
) (
  input  logic                    UserCLK,
  input  logic                    Reset,
  input  logic [NUM_CH-1:0]       I,
  output logic [NUM_CH-1:0]       O,          // EXTERNAL
  input  logic [NoConfigBits-1:0] ConfigBits  // GLOBAL
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    out_pass_chan #(
      .PIPE_DEPTH(PIPE_DEPTH)
    ) u_chan (
      .i_clk  (UserCLK),
      .i_rst  (Reset),
      .i_d    (I[g]),
      .i_mode (ConfigBits[MODE_W*g +: MODE_W]),
`ifdef OUT_PASS_INVERT_EN
      .i_inv  (ConfigBits[MODE_W*NUM_CH + g]),
`endif
      .o_q    (O[g])
    );
  end

endmodule

// File: tb/tb_out_pass_pipe.sv
// Directed bench for out_pass_pipe (NUM_CH=8, PIPE_DEPTH=3).
module tb_out_pass_pipe;

  localparam int NUM_CH     = 8;
  localparam int PIPE_DEPTH = 3;
`ifdef OUT_PASS_INVERT_EN
  localparam int NCFG = 3 * NUM_CH;
`else
  localparam int NCFG = 2 * NUM_CH;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       din;
  logic [7:0]       dout;
  logic [NCFG-1:0]  cfg;
  int               n_checks = 0;
  int               n_errors = 0;

  always #5 clk = ~clk;

  out_pass_pipe #(
    .NUM_CH     (NUM_CH),
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_dut (
    .UserCLK    (clk),
    .Reset      (rst),
    .I          (din),
    .O          (dout),
    .ConfigBits (cfg)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din = 8'h00;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] patt;
    logic [63:0] hist;
    logic [5:0]  rise_pat;
    logic        bit_v;
    logic        exp_v;

    patt     = 32'hB5C3_96E1;
    rise_pat = 6'b101110;
    hist     = 64'd0;

    // Reset behaviour with every channel in REG1
    cfg = NCFG'(16'h5555);
    din = 8'hFF;
    rst = 1'b1;
    #1;
    check_val("reset_during_pre_edge", 32'(dout), 32'h00);
    next_cycle();
    check_val("reset_during_post_edge", 32'(dout), 32'h00);
    rst = 1'b0;
    #1;
    check_val("reset_cycle_after", 32'(dout), 32'h00);
    next_cycle();
    check_val("reg1_all_ff", 32'(dout), 32'hFF);
    cfg = NCFG'(16'hAAAA);
    #1;
    check_val("regn_not_yet", 32'(dout), 32'h00);
    cfg = NCFG'(16'hFFFF);
    #1;
    check_val("rise_all_first", 32'(dout), 32'hFF);

    // BYPASS ignores Reset
    cfg = NCFG'(16'h0000);
    din = 8'hA5;
    #1;
    check_val("bypass_a5", 32'(dout), 32'hA5);
    rst = 1'b1;
    #1;
    check_val("bypass_a5_rst", 32'(dout), 32'hA5);
    next_cycle();
    check_val("bypass_a5_rst_edge", 32'(dout), 32'hA5);
    din = 8'h5A;
    #1;
    check_val("bypass_5a_rst", 32'(dout), 32'h5A);
    rst = 1'b0;
    #1;
    check_val("bypass_5a", 32'(dout), 32'h5A);

    // ch0 REG1, ch1 REGN: single pulse at cycle 10
    cfg = NCFG'(16'h0009);
    do_reset();
    for (int c = 0; c < 16; c++) begin
      din = (c == 10) ? 8'h03 : 8'h00;
      @(negedge clk);
      check_val($sformatf("reg1_pulse_c%0d", c), 32'(dout[0]), 32'(c == 11));
      check_val($sformatf("regn_pulse_c%0d", c), 32'(dout[1]), 32'(c == 13));
      next_cycle();
    end

    // ch2 RISE with 0,1,1,1,0,1
    cfg = NCFG'(16'h0030);
    do_reset();
    for (int c = 0; c < 10; c++) begin
      din    = 8'h00;
      din[2] = (c < 6) ? rise_pat[c] : 1'b0;
      @(negedge clk);
      check_val($sformatf("rise_seq_c%0d", c), 32'(dout[2]), 32'((c == 2) || (c == 6)));
      next_cycle();
    end

    // ch1 REGN and ch2 RISE streaming 1s across a reset at cycle 20
    cfg = NCFG'(16'h0038);
    do_reset();
    for (int c = 0; c < 28; c++) begin
      din = 8'h06;
      rst = (c == 20);
      @(negedge clk);
      check_val($sformatf("regn_rst_c%0d", c), 32'(dout[1]),
                32'(((c >= 3) && (c <= 19)) || (c >= 24)));
      check_val($sformatf("rise_rst_c%0d", c), 32'(dout[2]), 32'((c == 1) || (c == 22)));
      next_cycle();
    end
    rst = 1'b0;

    // ch3 REG1 -> REGN at cycle 30 without flushing
    do_reset();
    for (int c = 0; c < 36; c++) begin
      cfg     = (c >= 30) ? NCFG'(16'h0080) : NCFG'(16'h0040);
      bit_v   = patt[c % 32];
      hist[c] = bit_v;
      din     = 8'h00;
      din[3]  = bit_v;
      if (c >= 30)     exp_v = hist[c-3];
      else if (c >= 1) exp_v = hist[c-1];
      else             exp_v = 1'b0;
      @(negedge clk);
      check_val($sformatf("mode_switch_c%0d", c), 32'(dout[3]), 32'(exp_v));
      next_cycle();
    end

`ifdef OUT_PASS_INVERT_EN
    // ch4 REG1 inverted
    cfg = NCFG'(24'h100100);
    din = 8'h00;
    rst = 1'b1;
    #1;
    check_val("inv_reset", 32'(dout[4]), 32'h1);
    next_cycle();
    rst    = 1'b0;
    din[4] = 1'b1;
    #1;
    check_val("inv_after_reset", 32'(dout[4]), 32'h1);
    next_cycle();
    din = 8'h00;
    #1;
    check_val("inv_one", 32'(dout[4]), 32'h0);
    next_cycle();
    check_val("inv_back", 32'(dout[4]), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
